// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control unit: a Moore FSM that steps each instruction
// through fetch, decode and the class-specific execute/memory/writeback states.
module mc_control_fsm #(
    parameter int EXT_OPS     = 1,
    parameter int TRAP_STICKY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur;
    logic   ready;

    assign state = cur;

    // Gating mem_ready with rst_n keeps the FETCH/MEMWR strobes quiet while reset is held.
    assign ready = mem_ready & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:   if (ready) cur <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYP:      cur <= EXECUTE;
                        OP_BEQ:       cur <= BRANCH;
                        OP_ADDI:      cur <= IMMEX;
                        OP_J:         cur <= JUMP;
                        OP_BNE:       cur <= (EXT_OPS != 0) ? BRANCH : TRAP;
                        OP_ORI:       cur <= (EXT_OPS != 0) ? IMMEX : TRAP;
                        default:      cur <= TRAP;
                    endcase
                end
                MEMADR:  cur <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (ready) cur <= MEMWB;
                MEMWR:   if (ready) cur <= FETCH;
                EXECUTE: cur <= ALUWB;
                IMMEX:   cur <= IMMWB;
                TRAP:    if (TRAP_STICKY == 0) cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

    // Everything defaults low so each state only names the controls it asserts.
    always_comb begin
        pcwrite   = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        pcsrc     = 2'b00;
        illegal   = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = ready;
                pcwrite = ready;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWR: begin
                iord     = 1'b1;
                memwrite = ready;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch    = (op == OP_BEQ);
                branch_ne = (op == OP_BNE);
            end
            IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = (op == OP_ORI) ? 2'b11 : 2'b00;
            end
            IMMWB:   regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter EXT_OPS, default 1, enabling bne (000101) and ori (001101) when 1; both are illegal when 0.
REQ-002 SHALL have parameter TRAP_STICKY, default 1: 1 = TRAP held until reset, 0 = TRAP returns to FETCH after one cycle.
REQ-003 SHALL have: clk  in  1  single clock, all state changes on rising edge.
REQ-004 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have: op  in  6  opcode field of the instruction register.
REQ-006 SHALL have: mem_ready  in  1  memory access completes this cycle.
REQ-007 SHALL have: pcwrite, branch, branch_ne, iord, memwrite, irwrite  out  1 each  PC/memory/IR controls.
REQ-008 SHALL have: regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls.
REQ-009 SHALL have: alusrcb  out  2  ALU B select (00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2).
REQ-010 SHALL have: aluop  out  2  00 add, 01 sub, 10 funct-decoded, 11 or.
REQ-011 SHALL have: pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 SHALL have: state  out  4  current state code; illegal  out  1  high in TRAP.

Function
REQ-013 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, TRAP=12; codes 13-15 SHALL go to FETCH next cycle with all strobes 0.
REQ-014 SHALL be Moore: outputs decode from state only, except the mem_ready gating in REQ-016/REQ-019.
REQ-015 SHALL drive every output not listed for a state to 0 in that state.
REQ-016 FETCH: alusrcb=01, aluop=00, pcsrc=00, iord=0; irwrite=pcwrite=mem_ready; stays in FETCH while mem_ready=0, else DECODE.
REQ-017 DECODE: alusrcb=11, aluop=00; next by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> IMMEX, 000010 -> JUMP, 000101/001101 -> BRANCH/IMMEX if EXT_OPS=1, any other -> TRAP.
REQ-018 MEMADR: alusrca=1, alusrcb=10, aluop=00; -> MEMRD if op=100011, else MEMWR.
REQ-019 MEMRD: iord=1, waits while mem_ready=0, then -> MEMWB; MEMWR: iord=1, memwrite=mem_ready, waits while mem_ready=0, then -> FETCH.
REQ-020 MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
REQ-021 EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB; ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-022 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 if op=000100, branch_ne=1 if op=000101 -> FETCH.
REQ-023 IMMEX: alusrca=1, alusrcb=10, aluop=11 if op=001101 else 00 -> IMMWB; IMMWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-024 JUMP: pcsrc=10, pcwrite=1 -> FETCH.
REQ-025 TRAP: illegal=1, all write strobes 0; next per TRAP_STICKY.
REQ-026 op SHALL be sampled only in DECODE and MEMADR/BRANCH/IMMEX; changes elsewhere SHALL have no effect.
REQ-027 Instruction latency with mem_ready=1: lw 5 cycles, sw/R-type/addi/ori 4, beq/bne 3, j 3.

Reset
REQ-028 rst_n=0 SHALL force state=FETCH asynchronously, independent of clk.
REQ-029 While rst_n=0, pcwrite, irwrite, memwrite, regwrite, branch, branch_ne, illegal SHALL be 0 regardless of mem_ready.
REQ-030 After rst_n rises, the first rising clk edge SHALL evaluate FETCH normally; reset mid-instruction SHALL abandon it with no further write strobe.

Verification
REQ-031 lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1, memtoreg=1 only in MEMWB.
REQ-032 sw, mem_ready low 3 cycles in MEMWR -> state holds 5 for 3 cycles, memwrite=0, then memwrite=1 one cycle, -> FETCH.
REQ-033 bne (000101) with EXT_OPS=1 -> 0,1,8,0, branch_ne=1, branch=0; same op with EXT_OPS=0 -> TRAP, illegal=1.
REQ-034 op=111111, TRAP_STICKY=1 -> state 12 held 10+ cycles, illegal=1, no strobes; TRAP_STICKY=0 -> FETCH after 1 cycle.
REQ-035 rst_n low asserted mid-MEMWB between edges -> state=0 immediately, regwrite=0 without a clk edge.
REQ-036 ori (001101) -> 0,1,9,10,0 with aluop=11, alusrcb=10 in IMMEX.
